// File: rtl/enc8b10b_multilane.sv
// ---------------------------------------------------------------------------
// enc8b10b_multilane
//   N-lane 8b/10b encoder using the IEEE 802.3 Clause 36 code tables.
//   LANES bytes are encoded per beat. Running disparity is chained
//   lane0 -> lane(LANES-1) inside a beat and carried from beat to beat.
//
// Parameters
//   LANES    bytes per beat (1..8); lane0 is transmitted first
//   RD_INIT  disparity loaded at reset and by rd_clr (0 = RD-, 1 = RD+)
//
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  encoder can take a beat
//   in_data    in   8*LANES  lane i byte = in_data[8i+7:8i] ({HGF,EDCBA})
//   in_k       in   LANES    lane i is a control (K) character
//   rd_clr     in   force stored RD to RD_INIT on a cycle with no transfer
//   out_valid  out  output beat valid
//   out_ready  in   downstream takes the beat
//   out_data   out  10*LANES lane i symbol = out_data[10i+9:10i], bit 9 = a
//   rd         out  stored RD after the last accepted beat
//   code_err   out  LANES    per-lane illegal K flag, aligned with out_data
//
// Configuration
//   ENC_KERR_EN  when defined, code_err flags K lanes whose byte is not a
//                legal K character. When undefined, code_err is tied to 0.
// ---------------------------------------------------------------------------
module enc8b10b_multilane #(
    parameter int LANES   = 2,
    parameter bit RD_INIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*LANES-1:0]    in_data,
    input  logic [LANES-1:0]      in_k,
    input  logic                  rd_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10*LANES-1:0]   out_data,
    output logic                  rd,
    output logic [LANES-1:0]      code_err
);

    // Handshake: a beat moves on a rising edge where valid and ready are
    // both high. in_ready = !out_valid | out_ready; a single output register
    // with no skid buffer, so a stalled output also stalls the input.

    // Legal K set: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
    function automatic logic k_legal(input logic [7:0] b, input logic k);
        logic [4:0] x;
        logic [2:0] y;
        x = b[4:0];
        y = b[7:5];
        return k && ((x == 5'd28) ||
                     ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                      (x == 5'd29) || (x == 5'd30))));
    endfunction

    // 5b/6b data table, abcdei, form selected by the incoming RD.
    function automatic logic [5:0] enc6(input logic [4:0] x, input logic r);
        logic [5:0] s;
        case (x)
            5'd0:    s = r ? 6'b011000 : 6'b100111;
            5'd1:    s = r ? 6'b100010 : 6'b011101;
            5'd2:    s = r ? 6'b010010 : 6'b101101;
            5'd3:    s = 6'b110001;
            5'd4:    s = r ? 6'b001010 : 6'b110101;
            5'd5:    s = 6'b101001;
            5'd6:    s = 6'b011001;
            5'd7:    s = r ? 6'b000111 : 6'b111000;
            5'd8:    s = r ? 6'b000110 : 6'b111001;
            5'd9:    s = 6'b100101;
            5'd10:   s = 6'b010101;
            5'd11:   s = 6'b110100;
            5'd12:   s = 6'b001101;
            5'd13:   s = 6'b101100;
            5'd14:   s = 6'b011100;
            5'd15:   s = r ? 6'b101000 : 6'b010111;
            5'd16:   s = r ? 6'b100100 : 6'b011011;
            5'd17:   s = 6'b100011;
            5'd18:   s = 6'b010011;
            5'd19:   s = 6'b110010;
            5'd20:   s = 6'b001011;
            5'd21:   s = 6'b101010;
            5'd22:   s = 6'b011010;
            5'd23:   s = r ? 6'b000101 : 6'b111010;
            5'd24:   s = r ? 6'b001100 : 6'b110011;
            5'd25:   s = 6'b100110;
            5'd26:   s = 6'b010110;
            5'd27:   s = r ? 6'b001001 : 6'b110110;
            5'd28:   s = 6'b001110;
            5'd29:   s = r ? 6'b010001 : 6'b101110;
            5'd30:   s = r ? 6'b100001 : 6'b011110;
            default: s = r ? 6'b010100 : 6'b101011;
        endcase
        return s;
    endfunction

    // 3b/4b table, fghj. r is the RD after the 6b sub-block.
    // k28n selects the inverted neutral forms used by K28.1/.2/.5/.6.
    function automatic logic [3:0] enc4(input logic [2:0] y, input logic r,
                                        input logic alt7, input logic k28n);
        logic [3:0] s;
        case (y)
            3'd0:    s = r ? 4'b0100 : 4'b1011;
            3'd1:    s = (k28n && !r) ? 4'b0110 : 4'b1001;
            3'd2:    s = (k28n && !r) ? 4'b1010 : 4'b0101;
            3'd3:    s = r ? 4'b0011 : 4'b1100;
            3'd4:    s = r ? 4'b0010 : 4'b1101;
            3'd5:    s = (k28n && !r) ? 4'b0101 : 4'b1010;
            3'd6:    s = (k28n && !r) ? 4'b1001 : 4'b0110;
            default: s = alt7 ? (r ? 4'b1000 : 4'b0111)
                              : (r ? 4'b0001 : 4'b1110);
        endcase
        return s;
    endfunction

    // Sub-block disparity rule: more ones than half -> RD+, fewer -> RD-,
    // balanced leaves RD unchanged.
    function automatic logic rd_update(input int ones, input int half,
                                       input logic r);
        if (ones > half)      return 1'b1;
        else if (ones < half) return 1'b0;
        else                  return r;
    endfunction

    // One lane: returns {rd_out, abcdei, fghj}.
    function automatic logic [10:0] enc_lane(input logic [7:0] b,
                                             input logic k,
                                             input logic r_in);
        logic [4:0] x;
        logic [2:0] y;
        logic       kl;
        logic       k28;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       r_mid;
        logic       alt7;
        x     = b[4:0];
        y     = b[7:5];
        kl    = k_legal(b, k);
        k28   = kl && (x == 5'd28);
        s6    = k28 ? (r_in ? 6'b110000 : 6'b001111) : enc6(x, r_in);
        r_mid = rd_update($countones(s6), 3, r_in);
        // A7 avoids a run of five equal bits across the sub-block boundary.
        alt7  = kl ||
                (!r_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                ( r_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
        s4    = enc4(y, r_mid, alt7, k28);
        return {rd_update($countones(s4), 2, r_mid), s6, s4};
    endfunction

    logic [10*LANES-1:0] enc_data;
    logic                enc_rd;
    logic [10:0]         lane_res;
    logic                xfer_in;

    always_comb begin
        enc_data = '0;
        enc_rd   = rd;
        lane_res = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_res              = enc_lane(in_data[8*i +: 8], in_k[i], enc_rd);
            enc_data[10*i +: 10]  = lane_res[9:0];
            enc_rd                = lane_res[10];
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign xfer_in  = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            rd        <= RD_INIT;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            out_data  <= enc_data;
            rd        <= enc_rd;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            // rd_clr only acts on cycles with no input transfer.
            if (rd_clr)    rd        <= RD_INIT;
        end
    end

`ifdef ENC_KERR_EN
    logic [LANES-1:0] enc_err;

    always_comb begin
        enc_err = '0;
        for (int i = 0; i < LANES; i++) begin
            enc_err[i] = in_k[i] && !k_legal(in_data[8*i +: 8], 1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_err <= '0;
        end else if (xfer_in) begin
            code_err <= enc_err;
        end
    end
`else
    assign code_err = '0;
`endif

endmodule

// File: tb/tb_enc8b10b_multilane.sv
module tb_enc8b10b_multilane;
  localparam int LANES   = 2;
  localparam bit RD_INIT = 1'b0;
  localparam int W       = 11 * LANES;  // {code_err, out_data}
`ifdef ENC_KERR_EN
  localparam bit KERR_EN = 1'b1;
`else
  localparam bit KERR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [8*LANES-1:0]  in_data = '0;
  logic [LANES-1:0]    in_k = '0;
  logic                rd_clr = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [10*LANES-1:0] out_data;
  logic                rd;
  logic [LANES-1:0]    code_err;

  enc8b10b_multilane #(.LANES(LANES), .RD_INIT(RD_INIT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_k      (in_k),
    .rd_clr    (rd_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rd        (rd),
    .code_err  (code_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n_in = 0;
  int dut_beats = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // RD- forms of the 5b/6b data codes (abcdei); the RD+ form of any
  // unbalanced code (and of D.7) is its complement.
  logic [5:0] d6_tab [0:31] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  // RD- forms of the 3b/4b data codes (fghj), index 7 = primary D.x.7.
  logic [3:0] d4_tab [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                               4'b1101, 4'b1010, 4'b0110, 4'b1110};

  // Returns {err, rd_out, 10-bit symbol}.
  function automatic logic [11:0] model_lane(input logic [7:0] b, input logic k, input logic rd_in);
    int x;
    int y;
    bit legal;
    bit use_a7;
    logic [5:0] s6;
    logic [3:0] s4;
    logic r;
    x = int'(b[4:0]);
    y = int'(b[7:5]);
    r = rd_in;
    legal = k && (x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
    s6 = (legal && x == 28) ? 6'b001111 : d6_tab[x];
    if (r && ($countones(s6) != 3 || s6 == 6'b111000)) s6 = ~s6;
    if ($countones(s6) > 3) r = 1'b1;
    else if ($countones(s6) < 3) r = 1'b0;
    if (y == 7) begin
      use_a7 = legal || (!r && (x == 17 || x == 18 || x == 20)) ||
               (r && (x == 11 || x == 13 || x == 14));
      s4 = use_a7 ? 4'b0111 : 4'b1110;
      if (r) s4 = ~s4;
    end else begin
      s4 = d4_tab[y];
      if (legal && (y == 1 || y == 2 || y == 5 || y == 6)) begin
        if (!r) s4 = ~s4;
      end else if (r && ($countones(s4) != 2 || y == 3)) begin
        s4 = ~s4;
      end
    end
    if ($countones(s4) > 2) r = 1'b1;
    else if ($countones(s4) < 2) r = 1'b0;
    return {k && !legal, r, s6, s4};
  endfunction

  // Returns {rd_out, err[LANES], symbols[10*LANES]}.
  function automatic logic [W:0] model_beat(input logic [8*LANES-1:0] d, input logic [LANES-1:0] k,
                                            input logic rd_in);
    logic [10*LANES-1:0] sym;
    logic [LANES-1:0] err;
    logic r;
    logic [11:0] res;
    r = rd_in;
    sym = '0;
    err = '0;
    for (int i = 0; i < LANES; i++) begin
      res = model_lane(d[8*i +: 8], k[i], r);
      sym[10*i +: 10] = res[9:0];
      r = res[10];
      err[i] = res[11] & KERR_EN;
    end
    return {r, err, sym};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         m_rd;
  logic [W:0]   m_next;

  assign m_next = model_beat(in_data, in_k, m_rd);

  // Accepted beats are queued; the output register holds the queue head.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_in <= n_in - exp_q.size();
      exp_q.delete();
      m_rd <= RD_INIT;
    end else if (in_valid && (exp_q.size() == 0 || out_ready)) begin
      exp_q.push_back(m_next[W-1:0]);
      m_rd <= m_next[W];
      n_in <= n_in + 1;
    end else if (rd_clr) begin
      m_rd <= RD_INIT;
    end
  end

  // Compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'((exp_q.size() == 0) || out_ready));
      check("rd", 64'(rd), 64'(m_rd));
      if (exp_q.size() != 0) begin
        check("out_data", 64'(out_data), 64'(exp_q[0][10*LANES-1:0]));
        check("code_err", 64'(code_err), 64'(exp_q[0][W-1:10*LANES]));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (out_valid && out_ready) dut_beats <= dut_beats + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [8*LANES-1:0] d, input logic [LANES-1:0] k, input logic clr);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    in_k     = k;
    rd_clr   = clr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rd_clr   = 1'b0;
  endtask

  task automatic idle_clr();
    @(posedge clk); #1;
    rd_clr = 1'b1;
    @(posedge clk); #1;
    rd_clr = 1'b0;
  endtask

  function automatic logic [7:0] pick_legal_k(input int idx);
    logic [7:0] b;
    if (idx < 8) b = {3'(idx), 5'd28};
    else if (idx == 8) b = 8'hF7;
    else if (idx == 9) b = 8'hFB;
    else if (idx == 10) b = 8'hFD;
    else b = 8'hFE;
    return b;
  endfunction

  task automatic drive_random();
    @(posedge clk); #1;
    in_valid  = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 3) != 0);
    rd_clr    = ($urandom_range(0, 15) == 0);
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 5))
        0: begin in_k[i] = 1'b1; in_data[8*i +: 8] = pick_legal_k($urandom_range(0, 11)); end
        1: begin in_k[i] = 1'b1; in_data[8*i +: 8] = 8'($urandom_range(0, 255)); end
        default: begin in_k[i] = 1'b0; in_data[8*i +: 8] = 8'($urandom_range(0, 255)); end
      endcase
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;

    // Reset state.
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_rd", 64'(rd), 64'(RD_INIT));
    check("rst_code_err", 64'(code_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // D.0.0 in both lanes from RD-, one clock latency.
    send(16'h0000, 2'b00, 1'b0);
    check("d000_valid", 64'(out_valid), 64'd1);
    check("d000_data", 64'(out_data), 64'({10'b1001110100, 10'b1001110100}));
    check("d000_rd", 64'(rd), 64'd0);

    // K28.5 twice: RD- form in lane0, RD+ form in lane1.
    send(16'hBCBC, 2'b11, 1'b0);
    check("k285x2_data", 64'(out_data), 64'({10'b1100000101, 10'b0011111010}));
    check("k285x2_rd", 64'(rd), 64'd0);

    // K28.5 then D.16.2.
    send(16'h50BC, 2'b01, 1'b0);
    check("k285_d162_data", 64'(out_data), 64'({10'b1001000101, 10'b0011111010}));
    check("k285_d162_rd", 64'(rd), 64'd0);

    // D.17.7 at RD- takes A7; D.0.0 follows at RD+.
    send(16'h00F1, 2'b00, 1'b0);
    check("d177_lane0", 64'(out_data[9:0]), 64'(10'b1000110111));
    check("d177_data", 64'(out_data), 64'({10'b0110001011, 10'b1000110111}));
    check("d177_rd", 64'(rd), 64'd1);

    // rd_clr on an idle cycle restores RD_INIT.
    idle_clr();
    check("rdclr_idle", 64'(rd), 64'(RD_INIT));

    // rd_clr on a transfer edge is ignored.
    send(16'h00BC, 2'b01, 1'b1);
    check("rdclr_xfer_data", 64'(out_data), 64'({10'b0110001011, 10'b0011111010}));
    check("rdclr_xfer_rd", 64'(rd), 64'd1);
    idle_clr();

    // K0.0 is not a legal K: encoded as D.0.0, flagged when checking is built in.
    send(16'h0000, 2'b01, 1'b0);
    check("k00_data", 64'(out_data), 64'({10'b1001110100, 10'b1001110100}));
    check("k00_err", 64'(code_err), 64'(KERR_EN ? 2'b01 : 2'b00));

    // Backpressure: out_ready low for 5 clocks with in_valid high.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    in_k      = 2'b00;
    @(posedge clk); #1;
    in_data = 16'h5678;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 1000; c++) drive_random();

    // Asynchronous reset mid-stream.
    @(posedge clk); #1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    check("arst_rd", 64'(rd), 64'(RD_INIT));
    @(posedge clk); #3;
    reset_n = 1'b1;

    for (int c = 0; c < 1000; c++) drive_random();

    // Drain.
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rd_clr    = 1'b0;
    for (int c = 0; c < 10 && out_valid; c++) begin
      @(posedge clk); #1;
    end
    check("drain_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("beat_count", 64'(dut_beats), 64'(n_in));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
